exe_stage: RTL
==============

# exe_stage

Execute stage of the ARM968E-S pipeline and the consumer of the decoder's `EXE_CMD`, `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `B` and `S` outputs.
- Computes the ALU result and the branch target.
- Owns the NZCV status register.
- Registers everything into the EX/MEM pipeline register.
- Supports freeze (hazard stall) and flush (taken-branch kill).

## Interface
Parameters:
- `WIDTH`, 32: datapath width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `freeze` input 1: hold all registers, including SR.
- `flush` input 1: kill the incoming instruction.
- `EXE_CMD` input 4: ALU opcode.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `B_in`, `S_in` input 1 each: decoded controls.
- `PC_in` input WIDTH: PC+4 of the instruction.
- `Val_Rn`, `Val2` input WIDTH: ALU operands A and B.
- `Val_Rm` input WIDTH: store data.
- `Imm24` input 24: branch offset.
- `Dest_in` input 4: destination register.
- `ALU_Res` output WIDTH: registered result.
- `Store_Val` output WIDTH: registered `Val_Rm`.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN` output 1: registered controls.
- `Dest` output 4: registered destination.
- `Br_taken` output 1: registered one-cycle branch pulse.
- `Br_addr` output WIDTH: registered branch target.
- `SR` output 4: status register, {N,Z,C,V}.

## Operation
EXE_CMD encoding (A=`Val_Rn`, B=`Val2`, Cin=`SR.C`):
- `0001` MOV: B.
- `1001` MVN: ~B.
- `0010` ADD: A+B.
- `0011` ADC: A+B+Cin.
- `0100` SUB: A−B.
- `0101` SBC: A−B−!Cin.
- `0110` AND: A&B.
- `0111` ORR: A|B.
- `1000` EOR: A^B.
- Any other code: result 0, flags computed as for a logical op.

Flags:
- Computed in a WIDTH+1 bit sum.
- N = res[WIDTH−1]; Z = (res==0).
- ADD/ADC: C = carry out; V = operands share a sign and the result sign differs.
- SUB/SBC: C = NOT borrow, i.e. SUB C=1 iff A≥B unsigned. V = operand signs differ and the result sign differs from A.
- Logical ops and MOV/MVN: C and V keep their SR values.

Branch and SR:
- Br_addr = PC_in + (sign-extended Imm24 << 2), modulo 2^WIDTH.
- SR is written only when `S_in` is set and `!freeze` and `!flush`.
- CMP/TST arrive as SUB/AND with `WB_EN_in=0`, `S_in=1`.

Pipeline register update priority per edge:
1. `rst`: all outputs and SR go to 0.
2. `freeze`: hold everything, even when `flush` is also asserted. A held flush is reapplied by the hazard unit.
3. `flush`: bubble. WB_EN, MEM_R_EN, MEM_W_EN and Br_taken are 0; data fields are don't-care, implemented as 0; SR holds.
4. Otherwise: load computed values; Br_taken = B_in.

## Timing
- Latency: inputs to registered outputs in 1 cycle.
- Br_taken is high for exactly one cycle per branch, unless frozen, in which case it holds.
- SR changes at the same edge as ALU_Res. The next instruction's ADC/SBC sees the new C with no bypass needed.
- Back-to-back S-setting ops: each sees the SR left by its predecessor.
- Reset asserted mid-operation clears all outputs and SR immediately (asynchronous). The first load occurs on the first edge after deassertion.
- Wrap-around: all sums truncate to WIDTH; the carry lives only in C.

## Configuration
- `EXE_PERF_CNT_EN` defined: adds 32-bit outputs `Instr_cnt` and `Br_cnt`.
  - `Instr_cnt` counts non-flushed, non-frozen edges where any of WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, S_in or B_in is set.
  - `Br_cnt` counts loaded branches.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Structure
- Shared package `arm_pkg`:
  - EXE_CMD localparams (`EXE_MOV` … `EXE_EOR`).
  - SR bit indices (`SR_N`=3, `SR_Z`=2, `SR_C`=1, `SR_V`=0).
  - `WIDTH` default.
- One combinational sub-module `alu`: A, B, Cin, EXE_CMD → res, {N,Z,C,V}.
- `exe_stage` holds the branch adder, SR, pipeline register and optional counters.

## Test plan
- ADD 0x7FFFFFFF+1, S=1 → next cycle ALU_Res=0x80000000, SR=1001 (N=1, V=1).
- SUB 5−5 then ADC 1+1 with S=1 → SR after SUB = 0110 (Z, C); ADC result = 3.
- B with PC_in=0x100, Imm24=0xFFFFFE → Br_taken pulses one cycle, Br_addr=0x0F8.
- Flush during ADD with WB_EN_in=1, S=1 → WB_EN=0, SR unchanged; freeze with flush → all outputs and SR held.
- CMP 3 vs 7 (SUB, WB_EN_in=0, S=1) → WB_EN=0, SR=1000; ORR with S=1 afterwards keeps C=0, V=0.
- rst asserted mid-stream between edges → outputs and SR read 0 before the next edge; with `EXE_PERF_CNT_EN`, 3 loads plus 1 branch give Instr_cnt=4, Br_cnt=1.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM968E-S pipeline constants (ALU opcodes, SR bit positions, datapath width)
package arm_pkg;
    localparam int WIDTH = 32;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID->EX operand/control bundle plus EX->MEM pipeline register and status outputs
//   master: decoder side; drives EXE_CMD, controls, PC_in, operands, Imm24, Dest_in; observes results
//   slave : exe_stage; consumes the above, drives ALU_Res, Store_Val, WB/MEM enables, Dest, Br_*, SR
interface exe_stage_if #(parameter int WIDTH = arm_pkg::WIDTH);
    logic [3:0]       EXE_CMD;
    logic             WB_EN_in;
    logic             MEM_R_EN_in;
    logic             MEM_W_EN_in;
    logic             B_in;
    logic             S_in;
    logic [WIDTH-1:0] PC_in;
    logic [WIDTH-1:0] Val_Rn;
    logic [WIDTH-1:0] Val2;
    logic [WIDTH-1:0] Val_Rm;
    logic [23:0]      Imm24;
    logic [3:0]       Dest_in;
    logic [WIDTH-1:0] ALU_Res;
    logic [WIDTH-1:0] Store_Val;
    logic             WB_EN;
    logic             MEM_R_EN;
    logic             MEM_W_EN;
    logic [3:0]       Dest;
    logic             Br_taken;
    logic [WIDTH-1:0] Br_addr;
    logic [3:0]       SR;
    modport master (
        output EXE_CMD, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
               PC_in, Val_Rn, Val2, Val_Rm, Imm24, Dest_in,
        input  ALU_Res, Store_Val, WB_EN, MEM_R_EN, MEM_W_EN, Dest, Br_taken, Br_addr, SR
    );
    modport slave (
        input  EXE_CMD, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
               PC_in, Val_Rn, Val2, Val_Rm, Imm24, Dest_in,
        output ALU_Res, Store_Val, WB_EN, MEM_R_EN, MEM_W_EN, Dest, Br_taken, Br_addr, SR
    );
endinterface

// File: rtl/alu.sv
// alu: combinational ALU; a_i/b_i operands, cin_i/vin_i current SR.C/SR.V, cmd_i opcode -> res_o, nzcv_o
module alu #(parameter int WIDTH = arm_pkg::WIDTH) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             vin_i,
    input  logic [3:0]       cmd_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       nzcv_o
);
    import arm_pkg::*;
    logic             add_op;
    logic             sub_op;
    logic             carry_in;
    logic             b_sign;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;
    always_comb begin
        add_op   = (cmd_i == EXE_ADD) || (cmd_i == EXE_ADC);
        sub_op   = (cmd_i == EXE_SUB) || (cmd_i == EXE_SBC);
        carry_in = (cmd_i == EXE_ADC || cmd_i == EXE_SBC) ? cin_i : (cmd_i == EXE_SUB);
        // subtraction runs as A + ~B + 1 (SBC: + Cin), so the carry-out is NOT borrow
        sum      = {1'b0, a_i} + {1'b0, sub_op ? ~b_i : b_i} + {{WIDTH{1'b0}}, carry_in};
        case (cmd_i)
            EXE_MOV:                            res_o = b_i;
            EXE_MVN:                            res_o = ~b_i;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: res_o = sum[WIDTH-1:0];
            EXE_AND:                            res_o = a_i & b_i;
            EXE_ORR:                            res_o = a_i | b_i;
            EXE_EOR:                            res_o = a_i ^ b_i;
            default:                            res_o = '0;
        endcase
        // overflow: A and effective B share a sign that the result does not
        b_sign   = sub_op ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
        c        = (add_op || sub_op) ? sum[WIDTH] : cin_i;
        v        = (add_op || sub_op) ? (a_i[WIDTH-1] == b_sign) && (res_o[WIDTH-1] != a_i[WIDTH-1]) : vin_i;
        nzcv_o   = {res_o[WIDTH-1], res_o == '0, c, v};
    end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: ARM968E-S execute stage with ALU, branch adder, NZCV register and EX/MEM pipeline register
//   clk, rst (async, active-high), freeze (hold all state), flush (bubble the incoming instruction)
//   bus: exe_stage_if.slave carrying decoded controls/operands in and registered EX/MEM fields + SR out
//   Instr_cnt, Br_cnt: performance counters, present only when EXE_PERF_CNT_EN is defined
module exe_stage #(parameter int WIDTH = arm_pkg::WIDTH) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    exe_stage_if.slave  bus
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [31:0] Instr_cnt,
    output logic [31:0] Br_cnt
`endif
);
    import arm_pkg::*;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_nzcv;
    logic [WIDTH-1:0] br_target;
    logic             load;
    logic [WIDTH-1:0] alu_res_q, alu_res_d;
    logic [WIDTH-1:0] store_val_q, store_val_d;
    logic [WIDTH-1:0] br_addr_q, br_addr_d;
    logic             wb_en_q, wb_en_d;
    logic             mem_r_en_q, mem_r_en_d;
    logic             mem_w_en_q, mem_w_en_d;
    logic             br_taken_q, br_taken_d;
    logic [3:0]       dest_q, dest_d;
    logic [3:0]       sr_q, sr_d;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i    (bus.Val_Rn),
        .b_i    (bus.Val2),
        .cin_i  (sr_q[SR_C]),
        .vin_i  (sr_q[SR_V]),
        .cmd_i  (bus.EXE_CMD),
        .res_o  (alu_res),
        .nzcv_o (alu_nzcv)
    );

    // word offset: sign-extend the 24-bit field and scale by 4
    assign br_target = bus.PC_in + {{(WIDTH-26){bus.Imm24[23]}}, bus.Imm24, 2'b00};
    assign load      = !freeze && !flush;

    // freeze holds everything (even over flush); flush zeroes the fields but keeps SR
    always_comb begin
        alu_res_d   = freeze ? alu_res_q   : flush ? '0 : alu_res;
        store_val_d = freeze ? store_val_q : flush ? '0 : bus.Val_Rm;
        br_addr_d   = freeze ? br_addr_q   : flush ? '0 : br_target;
        dest_d      = freeze ? dest_q      : flush ? '0 : bus.Dest_in;
        wb_en_d     = freeze ? wb_en_q     : load && bus.WB_EN_in;
        mem_r_en_d  = freeze ? mem_r_en_q  : load && bus.MEM_R_EN_in;
        mem_w_en_d  = freeze ? mem_w_en_q  : load && bus.MEM_W_EN_in;
        br_taken_d  = freeze ? br_taken_q  : load && bus.B_in;
        sr_d        = (load && bus.S_in) ? alu_nzcv : sr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q   <= '0;
            store_val_q <= '0;
            br_addr_q   <= '0;
            dest_q      <= '0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            sr_q        <= '0;
        end else begin
            alu_res_q   <= alu_res_d;
            store_val_q <= store_val_d;
            br_addr_q   <= br_addr_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            br_taken_q  <= br_taken_d;
            sr_q        <= sr_d;
        end
    end

    assign bus.ALU_Res   = alu_res_q;
    assign bus.Store_Val = store_val_q;
    assign bus.Br_addr   = br_addr_q;
    assign bus.Dest      = dest_q;
    assign bus.WB_EN     = wb_en_q;
    assign bus.MEM_R_EN  = mem_r_en_q;
    assign bus.MEM_W_EN  = mem_w_en_q;
    assign bus.Br_taken  = br_taken_q;
    assign bus.SR        = sr_q;

`ifdef EXE_PERF_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] br_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            br_cnt_q    <= '0;
        end else if (load) begin
            if (bus.WB_EN_in || bus.MEM_R_EN_in || bus.MEM_W_EN_in || bus.S_in || bus.B_in)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (bus.B_in)
                br_cnt_q <= br_cnt_q + 32'd1;
        end
    end
    assign Instr_cnt = instr_cnt_q;
    assign Br_cnt    = br_cnt_q;
`endif
endmodule
